// File: rtl/io_pkg.sv
// Shared definitions for the IN-path input capture stage: FSM encoding,
// button polarity and the default debounce interval.
package io_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_WAIT_RELEASE = 2'd1,
    ST_WAIT_PRESS   = 2'd2,
    ST_DONE         = 2'd3
  } state_t;

  localparam logic BTN_PRESSED  = 1'b0;
  localparam logic BTN_RELEASED = 1'b1;

  // 10 ms at 50 MHz
  localparam int DEF_DEBOUNCE_CYCLES = 500000;

endpackage

// File: rtl/debounce_filter.sv
// Single-bit 2-flop synchroniser followed by a stable-count debouncer.
// The output only follows the synchronised input after DEBOUNCE_CYCLES steady cycles.
module debounce_filter
  import io_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter logic RESET_LEVEL     = BTN_RELEASED
) (
  input  logic clock,
  input  logic reset,
  input  logic in,
  output logic out
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;

  // Counter clears whenever input agrees with the accepted level, so it
  // saturates at CNT_LAST at most and cannot wrap.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1 <= RESET_LEVEL;
      r_sync2 <= RESET_LEVEL;
      r_level <= RESET_LEVEL;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= in;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign out = r_level;

endmodule

// File: rtl/io_input_capture.sv
// Input handshake stage for the CPU IN path: synchronises switches and the
// confirm button, and hands one switch sample per request with a valid pulse.
module io_input_capture
  import io_pkg::*;
#(
  parameter int DATA_W          = 6,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              btn_n,
  input  logic [DATA_W-1:0] switches,
  input  logic              req,
  output logic [DATA_W-1:0] data_out,
  output logic              valid,
  output logic              waiting
);

  logic              w_btn_db;
  logic [DATA_W-1:0] r_sw_sync1;
  logic [DATA_W-1:0] r_sw_sync2;
  state_t            r_state;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_waiting;

  debounce_filter #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .RESET_LEVEL     (BTN_RELEASED)
  ) u_btn_db (
    .clock (clock),
    .reset (reset),
    .in    (btn_n),
    .out   (w_btn_db)
  );

  // Switches are only sampled at the press, so a plain synchroniser suffices.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sw_sync1 <= '0;
      r_sw_sync2 <= '0;
    end else begin
      r_sw_sync1 <= switches;
      r_sw_sync2 <= r_sw_sync1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_waiting <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req) begin
            r_state   <= ST_WAIT_RELEASE;
            r_waiting <= 1'b1;
          end
        end
        // A button still held from the previous IN must be let go first.
        ST_WAIT_RELEASE: begin
          if (!req) begin
            r_state   <= ST_IDLE;
            r_waiting <= 1'b0;
          end else if (w_btn_db == BTN_RELEASED) begin
            r_state <= ST_WAIT_PRESS;
          end
        end
        ST_WAIT_PRESS: begin
          if (!req) begin
            r_state   <= ST_IDLE;
            r_waiting <= 1'b0;
          end else if (w_btn_db == BTN_PRESSED) begin
            r_state   <= ST_DONE;
            r_data    <= r_sw_sync2;
            r_valid   <= 1'b1;
            r_waiting <= 1'b0;
          end
        end
        ST_DONE: begin
          if (!req) r_state <= ST_IDLE;
        end
        default: begin
          r_state   <= ST_IDLE;
          r_waiting <= 1'b0;
        end
      endcase
    end
  end

  assign data_out = r_data;
  assign valid    = r_valid;
  assign waiting  = r_waiting;

endmodule
